// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// master = the arbiter; slave = the requesters plus the serial transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 new_tx_data;
  logic                 tx_busy;
  logic                 arb_busy;
  logic                 timeout_err;

  modport master (
    input  req, req_data, req_valid, req_last, tx_busy,
    output req_ready, grant, tx_data, new_tx_data, arb_busy, timeout_err
  );

  modport slave (
    output req, req_data, req_valid, req_last, tx_busy,
    input  req_ready, grant, tx_data, new_tx_data, arb_busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    HOLD1 = 2'd2,
    HOLD2 = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               new_tx_q, new_tx_d;
  logic               timeout_q, timeout_d;
  logic               last_flag_q, last_flag_d;
  logic [TO_W-1:0]    wd_q, wd_d;

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [7:0]         byte_arr [NUM_REQ];
  logic               g_req, g_valid, g_last, accept;
  logic [NUM_REQ-1:0] req_ready;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) byte_arr[i] = bus.req_data[i*8 +: 8];
  end

  assign g_req   = bus.req[gidx_q];
  assign g_valid = bus.req_valid[gidx_q];
  assign g_last  = bus.req_last[gidx_q];
  assign accept  = (state_q == SEND) && g_valid && !bus.tx_busy;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[IDX_W'(i)]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] last_idx_q, last_idx_d;

  // Search starts just past the last winner, so that winner ranks lowest.
  always_comb begin
    int cand;
    cand      = 0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_idx_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_found && bus.req[IDX_W'(cand)]) begin
        sel_idx   = IDX_W'(cand);
        sel_found = 1'b1;
      end
    end
  end

  assign last_idx_d = (state_q == IDLE && sel_found) ? sel_idx : last_idx_q;

  always_ff @(posedge clk) begin
    if (rst) last_idx_q <= IDX_W'(NUM_REQ - 1);
    else     last_idx_q <= last_idx_d;
  end
`endif

  // NOTE: the reset here is synchronous (sampled only on clk), matching the
  // rest of this codebase; tx_data is reset too so the bus idles at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      tx_data_q   <= '0;
      new_tx_q    <= 1'b0;
      timeout_q   <= 1'b0;
      last_flag_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      tx_data_q   <= tx_data_d;
      new_tx_q    <= new_tx_d;
      timeout_q   <= timeout_d;
      last_flag_q <= last_flag_d;
      wd_q        <= wd_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    tx_data_d   = tx_data_q;
    new_tx_d    = 1'b0;
    timeout_d   = 1'b0;
    last_flag_d = last_flag_q;
    wd_d        = wd_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = NUM_REQ'(1) << sel_idx;
          gidx_d  = sel_idx;
          wd_d    = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_data_d   = byte_arr[gidx_q];
          new_tx_d    = 1'b1;
          // A byte taken while req drops closes the packet like a last byte.
          last_flag_d = g_last || !g_req;
          wd_d        = '0;
          state_d     = HOLD1;
        end else if (!g_req) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      HOLD1: state_d = HOLD2;
      HOLD2: begin
        if (last_flag_q) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == SEND) req_ready[gidx_q] = !bus.tx_busy;
  end

  assign bus.req_ready   = req_ready;
  assign bus.arb_busy    = (state_q != IDLE);
  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_q;
  assign bus.timeout_err = timeout_q;

endmodule
